// File: rtl/prog_loader_if.sv
// Byte stream from the upstream receiver plus the memory write port driven by the loader.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;

    // master: the loader (consumes bytes, masters the memory write port)
    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_data, mem_wren
    );

    // slave: the surroundings (byte source and memory)
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses an (addr, len, data..., checksum) frame and writes the data bytes
// into instruction memory while holding the CPU in reset.
module prog_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    prog_loader_if.master     bus_io,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] byte_count_o
);

    typedef enum logic [2:0] {
        StIdle, StGetAddr, StGetLen, StData, StCheck, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;

    logic in_frame;
    logic accept;

    assign in_frame = (state_q == StGetAddr) || (state_q == StGetLen) ||
                      (state_q == StData)    || (state_q == StCheck);
    assign accept   = bus_io.rx_valid && in_frame;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        error_d    = error_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_en_i) begin
                    state_d = StGetAddr;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            StGetAddr: begin
                if (accept) begin
                    ptr_d   = bus_io.rx_data[ADDR_W-1:0];
                    state_d = StGetLen;
                end
            end
            StGetLen: begin
                if (accept) begin
                    rem_d   = bus_io.rx_data;
                    state_d = (bus_io.rx_data == '0) ? StCheck : StData;
                end
            end
            StData: begin
                if (accept) begin
                    mem_wren_d = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_data_d = bus_io.rx_data;
                    ptr_d      = ptr_q + ADDR_W'(1);
                    sum_d      = sum_q + bus_io.rx_data;
                    cnt_d      = cnt_q + ADDR_W'(1);
                    rem_d      = rem_q - DATA_W'(1);
                    if (rem_q == DATA_W'(1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    done_d  = (bus_io.rx_data == sum_q);
                    error_d = (bus_io.rx_data != sum_q);
                    state_d = (bus_io.rx_data == sum_q) ? StDone : StError;
                end
            end
            StDone, StError: begin
                if (!load_en_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins the state transition; a write already decoded above still issues.
        if (in_frame && !load_en_i) begin
            state_d = StIdle;
            done_d  = 1'b0;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            rem_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
        end
    end

    assign bus_io.rx_ready = in_frame;
    assign bus_io.mem_addr = mem_addr_q;
    assign bus_io.mem_data = mem_data_q;
    assign bus_io.mem_wren = mem_wren_q;
    assign cpu_hold_o      = (state_q != StIdle);
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign byte_count_o    = cnt_q;

endmodule
